// File: rtl/axi_lite_intc_pkg.sv
// Shared register map, response codes and decode helpers for the AXI4-Lite interrupt controller.
package axi_lite_intc_pkg;
   localparam logic [31:0] ADDR_GIE  = 32'h00;
   localparam logic [31:0] ADDR_IER  = 32'h04;
   localparam logic [31:0] ADDR_ISR  = 32'h08;
   localparam logic [31:0] ADDR_IAR  = 32'h0C;
   localparam logic [31:0] ADDR_IPR  = 32'h10;
   localparam logic [31:0] ADDR_ITR  = 32'h14;
   localparam logic [31:0] ADDR_ISET = 32'h18;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      REG_GIE  = 3'd0,
      REG_IER  = 3'd1,
      REG_ISR  = 3'd2,
      REG_IAR  = 3'd3,
      REG_IPR  = 3'd4,
      REG_ITR  = 3'd5,
      REG_ISET = 3'd6,
      REG_NONE = 3'd7
   } reg_idx_t;

   // Byte offsets beyond the last register decode to REG_NONE (SLVERR).
   function automatic reg_idx_t decode_reg(input logic [31:0] addr);
      if (addr > ADDR_ISET) return REG_NONE;
      return reg_idx_t'(addr[4:2]);
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] mask;
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
      return mask;
   endfunction
endpackage

// File: rtl/intc_src_sync.sv
// One interrupt source: synchroniser chain, delay flop and registered rising-edge pulse.
// level and rise both appear C_SYNC_STAGES+1 edges after the input is first sampled.
module intc_src_sync #(
   parameter int C_SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);
   logic [C_SYNC_STAGES-1:0] sync_q;
   logic                     dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync_q <= {sync_q[C_SYNC_STAGES-2:0], din};
         dly_q  <= sync_q[C_SYNC_STAGES-1];
         rise   <= sync_q[C_SYNC_STAGES-1] & ~dly_q;
      end
   end

   assign level = dly_q;
endmodule

// File: rtl/axi_lite_intc_multi.sv
// AXI4-Lite interrupt controller: C_NUM_INTR edge/level sources aggregated onto one registered irq.
// Single outstanding transaction per channel; responses are held until bready/rready.
module axi_lite_intc_multi
   import axi_lite_intc_pkg::*;
#(
   parameter int C_NUM_INTR        = 8,
   parameter int C_S_ADDR_WIDTH    = 5,
   parameter int C_S_DATA_WIDTH    = 32,
   parameter int C_SYNC_STAGES     = 2,
   parameter int C_IRQ_ACTIVE_HIGH = 1
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [C_NUM_INTR-1:0]         intr_in,
   output logic                          irq,
   input  logic [C_S_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                    s_axi_awprot,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [C_S_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [C_S_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                    s_axi_arprot,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [C_S_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready
);
   localparam int  N      = C_NUM_INTR;
   localparam logic IRQ_ON = (C_IRQ_ACTIVE_HIGH != 0);

   logic [N-1:0] src_lvl, src_rise;
   logic         gie;
   logic [N-1:0] ier, isr, itr;
   logic         wr_rdy, ar_rdy, wr_hs, rd_hs;
   reg_idx_t     wr_reg, rd_reg;
   logic [31:0]  wmask, wv, rd_word;
   logic [N-1:0] wm_n, wv_n, set_bits, clr_bits;
   logic         unused;

   for (genvar g = 0; g < N; g++) begin : g_src
      intc_src_sync #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_sync (
         .clk  (ACLK),
         .rst  (ARESET),
         .din  (intr_in[g]),
         .level(src_lvl[g]),
         .rise (src_rise[g])
      );
   end

   assign s_axi_awready = wr_rdy;
   assign s_axi_wready  = wr_rdy;
   assign s_axi_arready = ar_rdy;
   assign wr_hs  = wr_rdy & s_axi_awvalid & s_axi_wvalid;
   assign rd_hs  = ar_rdy & s_axi_arvalid;
   assign wr_reg = decode_reg(32'(s_axi_awaddr));
   assign rd_reg = decode_reg(32'(s_axi_araddr));
   assign wmask  = strb_mask(s_axi_wstrb);
   assign wv     = s_axi_wdata & wmask;
   assign wm_n   = wmask[N-1:0];
   assign wv_n   = wv[N-1:0];
   assign set_bits = (wr_hs && wr_reg == REG_ISET) ? wv_n : '0;
   assign clr_bits = (wr_hs && wr_reg == REG_IAR)  ? wv_n : '0;
   assign unused = ^{s_axi_awprot, s_axi_arprot, wmask, wv};

   always_comb begin
      rd_word = '0;
      case (rd_reg)
         REG_GIE: rd_word[0]   = gie;
         REG_IER: rd_word[N-1:0] = ier;
         REG_ISR: rd_word[N-1:0] = isr;
         REG_IPR: rd_word[N-1:0] = isr & ier;
         REG_ITR: rd_word[N-1:0] = itr;
         default: rd_word = '0;
      endcase
   end

   // Ready is a single-cycle pulse; it cannot re-arm while a response is still pending.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_rdy       <= 1'b0;
         ar_rdy       <= 1'b0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_rvalid <= 1'b0;
         s_axi_rresp  <= RESP_OKAY;
         s_axi_rdata  <= '0;
      end else begin
         wr_rdy <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !wr_rdy;
         ar_rdy <= s_axi_arvalid && !s_axi_rvalid && !ar_rdy;
         if (wr_hs) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= (wr_reg == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
         if (rd_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rresp  <= (rd_reg == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
            s_axi_rdata  <= rd_word;
         end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         gie <= 1'b0;
         ier <= '0;
         itr <= '0;
      end else if (wr_hs) begin
         case (wr_reg)
            REG_GIE: if (wmask[0]) gie <= wv[0];
            REG_IER: ier <= (ier & ~wm_n) | wv_n;
            REG_ITR: itr <= (itr & ~wm_n) | wv_n;
            default: ;
         endcase
      end
   end

   // Set sources (edge or ISET) are OR'd in after the clear so they win a same-cycle collision.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         isr <= '0;
         irq <= ~IRQ_ON;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (itr[i]) isr[i] <= (isr[i] & ~clr_bits[i]) | src_rise[i] | set_bits[i];
            else        isr[i] <= src_lvl[i] | set_bits[i];
         end
         irq <= (gie && |(isr & ier)) ? IRQ_ON : ~IRQ_ON;
      end
   end
endmodule

// File: tb/tb_axi_lite_intc_multi.sv
// Directed bench for axi_lite_intc_multi: 8 sources, 6-bit address so offsets 0x20/0x24 are reachable.
module tb_axi_lite_intc_multi;
   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [7:0]  intr_in = '0;
   logic        irq;
   logic [5:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
   logic [2:0]  s_axi_awprot = '0, s_axi_arprot = '0;
   logic        s_axi_awvalid = 0, s_axi_awready, s_axi_wvalid = 0, s_axi_wready;
   logic [31:0] s_axi_wdata = '0, s_axi_rdata;
   logic [3:0]  s_axi_wstrb = '0;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic        s_axi_bvalid, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_arready;
   logic        s_axi_rvalid, s_axi_rready = 0;

   int checks = 0;
   int failures = 0;

   always #5 ACLK = ~ACLK;

   axi_lite_intc_multi #(
      .C_NUM_INTR(8), .C_S_ADDR_WIDTH(6), .C_S_DATA_WIDTH(32),
      .C_SYNC_STAGES(2), .C_IRQ_ACTIVE_HIGH(1)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .intr_in(intr_in), .irq(irq),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
      .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
      .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int n;
      @(negedge ACLK);
      s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_awready && n < 20) begin @(negedge ACLK); n++; end
      chk("wr_awready_in_time", 32'(n < 20), 32'd1);
      @(negedge ACLK);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
      n = 0;
      while (!s_axi_bvalid && n < 20) begin @(negedge ACLK); n++; end
      chk("wr_bvalid_in_time", 32'(n < 20), 32'd1);
      resp = s_axi_bresp;
      @(negedge ACLK);
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      @(negedge ACLK);
      s_axi_araddr = addr; s_axi_arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 20) begin @(negedge ACLK); n++; end
      chk("rd_arready_in_time", 32'(n < 20), 32'd1);
      @(negedge ACLK);
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
      n = 0;
      while (!s_axi_rvalid && n < 20) begin @(negedge ACLK); n++; end
      chk("rd_rvalid_in_time", 32'(n < 20), 32'd1);
      data = s_axi_rdata; resp = s_axi_rresp;
      @(negedge ACLK);
      s_axi_rready = 1'b0;
   endtask

   task automatic wr(input logic [5:0] addr, input logic [31:0] data);
      logic [1:0] r;
      axi_write(addr, data, 4'hF, r);
   endtask

   task automatic rd_chk(input string tag, input logic [5:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(addr, d, r);
      chk(tag, d, exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, d2;
      logic [1:0]  r, r2;
      int n, early, pulses;
      logic prev;

      // Reset state
      repeat (3) @(negedge ACLK);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_awready", 32'(s_axi_awready), 32'd0);
      chk("rst_wready", 32'(s_axi_wready), 32'd0);
      chk("rst_arready", 32'(s_axi_arready), 32'd0);
      chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
      chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
      chk("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
      chk("rst_rdata", s_axi_rdata, 32'd0);
      ARESET = 1'b0;

      // 1: edge source 0, latency and acknowledge
      axi_write(6'h00, 32'h1, 4'hF, r);
      chk("t1_gie_bresp", 32'(r), 32'd0);
      wr(6'h04, 32'h01);
      wr(6'h14, 32'h01);
      @(negedge ACLK); intr_in[0] = 1'b1;
      @(posedge ACLK);
      @(posedge ACLK);
      @(posedge ACLK);
      @(negedge ACLK); intr_in[0] = 1'b0;
      @(posedge ACLK); #1;
      chk("t1_irq_k3", 32'(irq), 32'd0);
      @(posedge ACLK); #1;
      chk("t1_irq_k4", 32'(irq), 32'd1);
      rd_chk("t1_ipr", 6'h10, 32'h1);
      rd_chk("t1_isr", 6'h08, 32'h1);
      wr(6'h0C, 32'h1);
      rd_chk("t1_ipr_after_iar", 6'h10, 32'h0);
      chk("t1_irq_after_iar", 32'(irq), 32'd0);

      // 2: level mode on source 7
      wr(6'h14, 32'h00);
      wr(6'h04, 32'h80);
      @(negedge ACLK); intr_in[7] = 1'b1;
      repeat (6) @(posedge ACLK);
      rd_chk("t2_isr_level", 6'h08, 32'h80);
      chk("t2_irq_level", 32'(irq), 32'd1);
      wr(6'h0C, 32'h80);
      rd_chk("t2_isr_iar_noeffect", 6'h08, 32'h80);
      @(negedge ACLK); intr_in[7] = 1'b0;
      @(posedge ACLK);
      @(posedge ACLK);
      @(posedge ACLK);
      @(posedge ACLK); #1;
      chk("t2_irq_k3", 32'(irq), 32'd1);
      @(posedge ACLK); #1;
      chk("t2_irq_k4", 32'(irq), 32'd0);
      rd_chk("t2_isr_dropped", 6'h08, 32'h00);

      // 3: edge on source 2 in the same cycle as IAR clearing it
      wr(6'h14, 32'h04);
      wr(6'h04, 32'h04);
      rd_chk("t3_isr_clean", 6'h08, 32'h00);
      @(negedge ACLK);
      intr_in[2] = 1'b1; s_axi_awaddr = 6'h0C; s_axi_wdata = 32'h04; s_axi_wstrb = 4'hF;
      @(negedge ACLK);
      @(negedge ACLK);
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      @(negedge ACLK);
      chk("t3_awready_aligned", 32'(s_axi_awready), 32'd1);
      @(negedge ACLK);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
      chk("t3_bvalid", 32'(s_axi_bvalid), 32'd1);
      @(negedge ACLK); s_axi_bready = 1'b0;
      rd_chk("t3_isr_set_wins", 6'h08, 32'h04);
      chk("t3_irq_active", 32'(irq), 32'd1);
      intr_in[2] = 1'b0;
      wr(6'h0C, 32'h04);
      rd_chk("t3_isr_cleared", 6'h08, 32'h00);
      chk("t3_irq_inactive", 32'(irq), 32'd0);

      // 4: software set with global enable off, then on
      wr(6'h00, 32'h0);
      wr(6'h14, 32'h0F);
      wr(6'h04, 32'h0F);
      wr(6'h18, 32'h0F);
      rd_chk("t4_isr_iset", 6'h08, 32'h0F);
      rd_chk("t4_ipr", 6'h10, 32'h0F);
      chk("t4_irq_masked", 32'(irq), 32'd0);
      wr(6'h00, 32'h1);
      chk("t4_irq_gie_on", 32'(irq), 32'd1);
      axi_write(6'h04, 32'hFF, 4'b0010, r);
      rd_chk("t4_ier_strobe", 6'h04, 32'h0F);

      // 5: unmapped offsets, ignored writes, split handshake, stalled read
      fork
         axi_write(6'h20, 32'h0, 4'hF, r);
         axi_read(6'h24, d, r2);
      join
      chk("t5_bresp_slverr", 32'(r), 32'd2);
      chk("t5_rresp_slverr", 32'(r2), 32'd2);
      chk("t5_rdata_zero", d, 32'd0);
      axi_read(6'h1C, d, r2);
      chk("t5_1c_slverr", 32'(r2), 32'd2);
      axi_read(6'h14, d, r2);
      chk("t5_itr_okay", 32'(r2), 32'd0);
      chk("t5_itr_val", d, 32'h0F);
      axi_write(6'h08, 32'h0, 4'hF, r);
      chk("t5_isr_wr_okay", 32'(r), 32'd0);
      rd_chk("t5_isr_wr_ignored", 6'h08, 32'h0F);
      rd_chk("t5_gie_kept", 6'h00, 32'h1);

      @(negedge ACLK);
      s_axi_awaddr = 6'h04; s_axi_wdata = 32'h3C; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0;
      early = 0;
      repeat (5) begin @(negedge ACLK); if (s_axi_awready) early++; end
      chk("t5_no_ready_without_w", 32'(early), 32'd0);
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_awready && n < 20) begin @(negedge ACLK); n++; end
      chk("t5_split_ready_in_time", 32'(n < 20), 32'd1);
      @(negedge ACLK);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      pulses = 0; prev = 1'b0;
      repeat (4) begin
         if (s_axi_bvalid && !prev) pulses++;
         prev = s_axi_bvalid;
         @(negedge ACLK);
      end
      chk("t5_bvalid_held", 32'(s_axi_bvalid), 32'd1);
      s_axi_bready = 1'b1;
      @(negedge ACLK); s_axi_bready = 1'b0;
      repeat (5) begin
         if (s_axi_bvalid && !prev) pulses++;
         prev = s_axi_bvalid;
         @(negedge ACLK);
      end
      chk("t5_single_bvalid", 32'(pulses), 32'd1);
      chk("t5_bvalid_done", 32'(s_axi_bvalid), 32'd0);
      rd_chk("t5_ier_split", 6'h04, 32'h3C);

      fork
         begin
            @(negedge ACLK);
            s_axi_araddr = 6'h08; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
            n = 0;
            while (!s_axi_arready && n < 20) begin @(negedge ACLK); n++; end
            chk("t5_stall_arready", 32'(n < 20), 32'd1);
            @(negedge ACLK); s_axi_arvalid = 1'b0;
            n = 0;
            while (!s_axi_rvalid && n < 20) begin @(negedge ACLK); n++; end
            chk("t5_stall_rvalid", 32'(n < 20), 32'd1);
            repeat (10) begin
               chk("t5_rdata_stable", s_axi_rdata, 32'h0F);
               @(negedge ACLK);
            end
            chk("t5_rvalid_held", 32'(s_axi_rvalid), 32'd1);
            s_axi_rready = 1'b1;
            @(negedge ACLK); s_axi_rready = 1'b0;
            chk("t5_rvalid_done", 32'(s_axi_rvalid), 32'd0);
         end
         begin
            @(negedge ACLK);
            @(negedge ACLK);
            wr(6'h0C, 32'h01);
         end
      join
      rd_chk("t5_isr_after_iar", 6'h08, 32'h0E);

      // 6: asynchronous reset with a write response pending and irq active
      @(negedge ACLK);
      s_axi_awaddr = 6'h00; s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
      n = 0;
      while (!s_axi_awready && n < 20) begin @(negedge ACLK); n++; end
      chk("t6_awready_in_time", 32'(n < 20), 32'd1);
      @(negedge ACLK);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      chk("t6_bvalid_pending", 32'(s_axi_bvalid), 32'd1);
      chk("t6_irq_before", 32'(irq), 32'd1);
      #2 ARESET = 1'b1;
      #1;
      chk("t6_bvalid_async", 32'(s_axi_bvalid), 32'd0);
      chk("t6_irq_async", 32'(irq), 32'd0);
      chk("t6_readies_async", 32'({s_axi_awready, s_axi_arready, s_axi_rvalid}), 32'd0);
      @(negedge ACLK); ARESET = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("t6_no_response", 32'(s_axi_bvalid), 32'd0);
      rd_chk("t6_gie", 6'h00, 32'h0);
      rd_chk("t6_ier", 6'h04, 32'h0);
      rd_chk("t6_isr", 6'h08, 32'h0);
      rd_chk("t6_ipr", 6'h10, 32'h0);
      rd_chk("t6_itr", 6'h14, 32'h0);
      d2 = s_axi_rdata;
      chk("t6_irq_after", 32'(irq), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
